// File: rtl/jk_ff_sequencer.sv
// Steps a JK flip-flop under test through a J/K pattern with clean
// registered clock pulses and checks Q/notQ against an ideal JK model.
module jk_ff_sequencer #(
    parameter int                     NUM_STEPS = 8,
    parameter logic [2*NUM_STEPS-1:0] PATTERN   = 16'h4BD2,
    parameter int                     HOLD      = 4
) (
    input  logic                         CLK50M,
    input  logic                         reset,
    input  logic                         button,
    input  logic                         auto_mode,
    input  logic                         q_in,
    input  logic                         notq_in,
    output logic                         j,
    output logic                         k,
    output logic                         ff_clk,
    output logic [$clog2(NUM_STEPS)-1:0] step,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [3:0]                   err_count
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CLK_HI, S_CLK_LO, S_CHECK, S_WAIT, S_DONE
    } state_t;

    state_t        state, state_n;
    logic          btn_d;
    logic          press;
    logic          model_q;
    logic          exp_q;
    logic          mismatch;
    logic [HW-1:0] hcnt;
    logic          timed;
    logic          hold_end;
    logic          last;
    logic [1:0]    pat_jk;

    assign press    = button & ~btn_d;
    assign timed    = (state == S_SETUP) | (state == S_CLK_HI) |
                      (state == S_CLK_LO);
    assign hold_end = (hcnt == HW'(HOLD - 1));
    assign last     = (step == SW'(NUM_STEPS - 1));
    assign pat_jk   = PATTERN[{step, 1'b0} +: 2];

    // Ideal JK next-state from the J/K currently applied to the flop.
    always_comb begin
        exp_q = model_q;
        unique case ({j, k})
            2'b10:   exp_q = 1'b1;
            2'b01:   exp_q = 1'b0;
            2'b11:   exp_q = ~model_q;
            default: exp_q = model_q;
        endcase
    end

    assign mismatch = (q_in != exp_q) | (notq_in != ~q_in);

    always_ff @(posedge CLK50M) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (press)    state_n = S_SETUP;
            S_SETUP:  if (hold_end) state_n = S_CLK_HI;
            S_CLK_HI: if (hold_end) state_n = S_CLK_LO;
            S_CLK_LO: if (hold_end) state_n = S_CHECK;
            S_CHECK:  state_n = last      ? S_DONE  :
                                auto_mode ? S_SETUP : S_WAIT;
            S_WAIT:   if (press)    state_n = S_SETUP;
            S_DONE:   if (press)    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE) & (state != S_DONE);
        done = (state == S_DONE);
        pass = done & ~fail;
    end

    always_ff @(posedge CLK50M) begin
        if (reset) begin
            btn_d     <= 1'b0;
            hcnt      <= '0;
            ff_clk    <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            step      <= '0;
            err_count <= '0;
            fail      <= 1'b0;
            model_q   <= 1'b0;
        end else begin
            btn_d  <= button;
            hcnt   <= (timed && state_n == state) ? hcnt + 1'b1 : '0;
            // Flop output: high exactly while the FSM sits in CLK_HI.
            ff_clk <= (state_n == S_CLK_HI);
            if (state_n == S_IDLE) begin
                j <= 1'b0;
                k <= 1'b0;
            end else if (state == S_SETUP) begin
                j <= pat_jk[1];
                k <= pat_jk[0];
            end
            case (state)
                S_IDLE: begin
                    if (press) begin
                        model_q   <= q_in;
                        step      <= '0;
                        err_count <= '0;
                        fail      <= 1'b0;
                    end
                end
                S_CHECK: begin
                    model_q <= exp_q;
                    if (mismatch) begin
                        fail <= 1'b1;
                        if (err_count != 4'd15)
                            err_count <= err_count + 1'b1;
                    end
                    if (!last) step <= step + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
